// File: rtl/byte_joining_pkg.sv
// Shared types and helpers for the byte joiner and its sibling striping block.
package byte_joining_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (value > 0) ? value - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Zero lanes becomes one lane; anything above the lane count saturates.
    function automatic int unsigned clamp_lanes(input int unsigned req,
                                                input int unsigned num_lanes);
        if (req == 0) begin
            return 1;
        end
        if (req > num_lanes) begin
            return num_lanes;
        end
        return req;
    endfunction

    function automatic logic lanes_illegal(input int unsigned req,
                                           input int unsigned num_lanes);
        return (req == 0) || (req > num_lanes);
    endfunction

endpackage

// File: rtl/byte_joining_lane_mux.sv
// Combinational lane selector: picks one WIDTH-bit lane out of a striped word.
module byte_joining_lane_mux #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned IW        = 2
) (
    input  logic [NUM_LANES*WIDTH-1:0] word,
    input  logic [IW-1:0]              sel,
    output logic [WIDTH-1:0]           lane
);

    always_comb begin
        lane = '0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            if (IW'(k) == sel) begin
                lane = word[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/byte_joining_param.sv
// Parametrised byte joiner: serialises striped words lane 0 first through a two-entry buffer.
// Optional parity output enabled by defining BYTE_JOINING_PARITY_EN.
module byte_joining_param
    import byte_joining_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned WIDTH     = 8,
    localparam int unsigned IW       = (clog2(NUM_LANES) > 0) ? clog2(NUM_LANES) : 1,
    localparam int unsigned CW       = clog2(NUM_LANES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_LANES*WIDTH-1:0] lanes_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CW-1:0]              active_lanes,
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IW-1:0]              lane_sel,
    output logic                       cfg_err
`ifdef BYTE_JOINING_PARITY_EN
    ,
    output logic                       parity_out
`endif
);

    state_e                     state_q, state_d;
    logic [NUM_LANES*WIDTH-1:0] ser_word_q, ser_word_d;
    logic [NUM_LANES*WIDTH-1:0] shd_word_q, shd_word_d;
    logic [CW-1:0]              ser_cnt_q, ser_cnt_d;
    logic [CW-1:0]              shd_cnt_q, shd_cnt_d;
    logic [CW-1:0]              cnt_in;
    logic                       shd_full_q, shd_full_d;
    logic [IW-1:0]              lane_sel_q, lane_sel_d;
    logic [WIDTH-1:0]           data_q, data_d, mux_lane;
    logic                       out_valid_q, out_valid_d;
    logic                       cfg_err_q, cfg_err_d;
    logic                       accept, xfer, last, upd;

    assign in_ready = !shd_full_q;
    assign accept   = in_valid && in_ready;
    assign cnt_in   = CW'(clamp_lanes(32'(active_lanes), NUM_LANES));
    assign xfer     = (state_q == ST_SEND) && out_ready;
    assign last     = xfer && ((32'(lane_sel_q) + 32'd1) == 32'(ser_cnt_q));

    always_comb begin
        state_d     = state_q;
        ser_word_d  = ser_word_q;
        ser_cnt_d   = ser_cnt_q;
        shd_word_d  = shd_word_q;
        shd_cnt_d   = shd_cnt_q;
        shd_full_d  = shd_full_q;
        lane_sel_d  = lane_sel_q;
        out_valid_d = out_valid_q;
        upd         = 1'b0;
        cfg_err_d   = cfg_err_q | (accept && lanes_illegal(32'(active_lanes), NUM_LANES));

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ser_word_d  = lanes_in;
                    ser_cnt_d   = cnt_in;
                    lane_sel_d  = '0;
                    upd         = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last) begin
                    // The shadow word always wins; in_ready is low while it is full.
                    if (shd_full_q) begin
                        ser_word_d = shd_word_q;
                        ser_cnt_d  = shd_cnt_q;
                        shd_full_d = 1'b0;
                        lane_sel_d = '0;
                        upd        = 1'b1;
                    end else if (accept) begin
                        ser_word_d = lanes_in;
                        ser_cnt_d  = cnt_in;
                        lane_sel_d = '0;
                        upd        = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    if (xfer) begin
                        lane_sel_d = lane_sel_q + IW'(1);
                        upd        = 1'b1;
                    end
                    if (accept) begin
                        shd_word_d = lanes_in;
                        shd_cnt_d  = cnt_in;
                        shd_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    byte_joining_lane_mux #(
        .NUM_LANES(NUM_LANES),
        .WIDTH    (WIDTH),
        .IW       (IW)
    ) u_lane_mux (
        .word(ser_word_d),
        .sel (lane_sel_d),
        .lane(mux_lane)
    );

    assign data_d = upd ? mux_lane : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ser_word_q  <= '0;
            ser_cnt_q   <= '0;
            shd_word_q  <= '0;
            shd_cnt_q   <= '0;
            shd_full_q  <= 1'b0;
            lane_sel_q  <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ser_word_q  <= ser_word_d;
            ser_cnt_q   <= ser_cnt_d;
            shd_word_q  <= shd_word_d;
            shd_cnt_q   <= shd_cnt_d;
            shd_full_q  <= shd_full_d;
            lane_sel_q  <= lane_sel_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = out_valid_q;
    assign lane_sel  = lane_sel_q;
    assign cfg_err   = cfg_err_q;

`ifdef BYTE_JOINING_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign parity_out = parity_q;
`endif

endmodule

// File: doc/byte_joining_param.md
Name: byte_joining_param

Overview:
- Parametrised successor to the fixed 4-lane, 8-bit byte joiner.
- Accepts one striped word of NUM_LANES lanes per handshake and emits the lane bytes serially, lane 0 first, on a single clock.
- The active lane count is selectable per word (x1/x2/x4-style link widths).
- Provides a two-entry buffer with valid/ready on both sides, so back-to-back words stream with no bubbles.
- Sits between the lane deskew/unstriping stage and the byte-wide downstream consumer.

Parameters:
- NUM_LANES, 4: number of input lanes; must be ≥ 1.
- WIDTH, 8: bits per lane and per output symbol.
- IW, derived = max(1, clog2(NUM_LANES)): lane index width.
- CW, derived = clog2(NUM_LANES+1): width of the active_lanes field.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- lanes_in  in  NUM_LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  1  lanes_in and active_lanes are valid.
- in_ready  out  1  block can accept a word this cycle.
- active_lanes  in  CW  lanes to emit for this word; sampled at acceptance.
- data_out  out  WIDTH  current output symbol.
- out_valid  out  1  data_out is valid.
- out_ready  in  1  downstream accepts data_out.
- lane_sel  out  IW  lane index of the current data_out.
- cfg_err  out  1  sticky flag for an illegal active_lanes value.

Behaviour:
- Reset state: data_out=0, out_valid=0, lane_sel=0, cfg_err=0, both buffer entries empty, FSM=IDLE. in_ready=1 once reset deasserts.
- Storage: serializer entry (SER) plus shadow entry (SHD). Each entry holds the word and its clamped lane count.
- in_ready = !SHD_full. It is combinational from registered state only; there is no path from in_valid or out_ready.
- Acceptance: a word is accepted when in_valid && in_ready at a rising edge.
  - It loads into SER if SER is empty or SER is completing its last byte in the same cycle.
  - Otherwise it loads into SHD.
- Lane count clamp: active_lanes==0 is treated as 1; active_lanes>NUM_LANES is treated as NUM_LANES. Either case sets cfg_err, which holds until reset.
- Latency: a word accepted at edge t presents lane 0 on data_out with out_valid=1 after edge t, i.e. first byte visible in cycle t+1.
- Output transfer occurs when out_valid && out_ready. On transfer lane_sel increments and data_out takes the next lane. All outputs are registered.
- Stall: while out_valid && !out_ready, data_out, lane_sel and out_valid hold stable.
- FSM IDLE:
  - out_valid=0.
  - Go to SEND when a word is accepted.
- FSM SEND, transfer of the last lane (lane_sel==count-1):
  - If SHD is full, move SHD into SER, set lane_sel=0, stay in SEND; SHD becomes empty and in_ready rises next cycle.
  - Else if a word is accepted in the same cycle, load it into SER, set lane_sel=0, stay in SEND.
  - Else go to IDLE with out_valid=0; data_out holds its last value.
- Throughput: with out_ready=1 and words always available, output is continuous at 1 symbol/clk with no gap between words.
- Single-lane words (count=1) reach the last lane immediately; the same rules apply.
- Reset mid-operation discards SER, SHD and any partial word; no symbol is emitted after reset deasserts until a new word is accepted.

Optional Feature:
- Macro BYTE_JOINING_PARITY_EN.
- When defined: adds output parity_out (1 bit), the even parity (XOR reduction) of data_out, registered alongside data_out. Reset value 0; it follows the same stall-hold rule.
- When not defined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package byte_joining_pkg:
  - FSM state encodings ST_IDLE=1'b0, ST_SEND=1'b1.
  - A clog2 constant function.
  - The lane-count clamp function shared with the striping block.
- Sub-module byte_joining_lane_mux: combinational select of WIDTH bits from a NUM_LANES*WIDTH vector by an IW-bit index. The top level instantiates it once, on the SER word.

Test Plan (NUM_LANES=4, WIDTH=8):
- Reset, then one word {L3=04,L2=02,L1=01,L0=00}, active_lanes=4, out_ready=1 -> data_out 00,01,02,04 on 4 consecutive cycles starting 1 cycle after acceptance; lane_sel 0..3; then out_valid=0.
- 16 words streamed with each lane incrementing by 1 per word, in_valid and out_ready held at 1 -> 64 contiguous symbols with no out_valid gaps; in_ready drops to 0 once both SER and SHD are full, and rises the cycle after each SHD→SER load.
- active_lanes=2 on word A (10,11,12,13) followed by active_lanes=4 on word B (20,21,22,23) -> output 10,11,20,21,22,23; cfg_err stays 0.
- out_ready low for 3 cycles while lane 1 is showing -> data_out=01, lane_sel=1 held stable for those 3 cycles; no symbol lost or duplicated.
- active_lanes=0, then active_lanes=7 -> first word emits lane 0 only, second word emits 4 lanes; cfg_err=1 and stays set until reset.
- reset asserted asynchronously mid-word (after lane 1) with SHD full -> all outputs 0 immediately and in_ready=1 after release; no residual symbols; parity_out=0 when BYTE_JOINING_PARITY_EN is defined.
